// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (DBIT data, run-time parity and stop count)
module uart_tx_cfg #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_s_tick,
    input  logic            i_tx_start,
    input  logic [DBIT-1:0] i_din,
    input  logic [1:0]      i_par_mode,
    input  logic            i_two_stop,
    output logic            o_busy,
    output logic            o_tx_done_tick,
    output logic            o_tx
);

    // Tick counter must reach both the bit-end count and the two-stop-bit count.
    localparam int SW_OS = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int SW_SB = (2 * SB_TICK > 1) ? $clog2(2 * SB_TICK) : 1;
    localparam int SW    = (SW_OS > SW_SB) ? SW_OS : SW_SB;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] OS_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SB1_LAST = SW'(SB_TICK - 1);
    localparam logic [SW-1:0] SB2_LAST = SW'(2 * SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_shift;
    logic            r_par_bit;
    logic            r_par_en;
    logic            r_two_stop;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;

    state_t          w_state_next;
    logic [SW-1:0]   w_s_next;
    logic [NW-1:0]   w_n_next;
    logic [DBIT-1:0] w_shift_next;
    logic            w_par_bit_next;
    logic            w_par_en_next;
    logic            w_two_stop_next;
    logic            w_tx_next;
    logic            w_busy_next;
    logic            w_done_next;

    logic [DBIT-1:0] w_shift_sh;
    logic            w_bit_end;
    logic            w_stop_end;

    assign w_shift_sh = r_shift >> 1;
    assign w_bit_end  = i_s_tick && (r_s == OS_LAST);
    assign w_stop_end = i_s_tick && (r_two_stop ? (r_s == SB2_LAST) : (r_s == SB1_LAST));

    // State and datapath registers; reset aborts any frame without a done pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_s        <= '0;
            r_n        <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_en   <= 1'b0;
            r_two_stop <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_s        <= w_s_next;
            r_n        <= w_n_next;
            r_shift    <= w_shift_next;
            r_par_bit  <= w_par_bit_next;
            r_par_en   <= w_par_en_next;
            r_two_stop <= w_two_stop_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    // Next-state logic; o_tx is computed one edge early so it changes on state entry.
    always_comb begin
        w_state_next    = r_state;
        w_s_next        = r_s;
        w_n_next        = r_n;
        w_shift_next    = r_shift;
        w_par_bit_next  = r_par_bit;
        w_par_en_next   = r_par_en;
        w_two_stop_next = r_two_stop;
        w_tx_next       = r_tx;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                if (i_tx_start) begin
                    w_state_next    = START;
                    w_s_next        = '0;
                    w_n_next        = '0;
                    w_shift_next    = i_din;
                    // Parity is taken from the accepted word, never the shifting copy.
                    w_par_bit_next  = (^i_din) ^ (i_par_mode == 2'b10);
                    w_par_en_next   = (i_par_mode == 2'b01) || (i_par_mode == 2'b10);
                    w_two_stop_next = i_two_stop;
                    w_tx_next       = 1'b0;
                    w_busy_next     = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_s_next     = '0;
                    w_state_next = DATA;
                    w_tx_next    = r_shift[0];
                end else if (i_s_tick) begin
                    w_s_next = r_s + 1'b1;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_s_next     = '0;
                    w_shift_next = w_shift_sh;
                    if (r_n == N_LAST) begin
                        if (r_par_en) begin
                            w_state_next = PARITY;
                            w_tx_next    = r_par_bit;
                        end else begin
                            w_state_next = STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_n_next  = r_n + 1'b1;
                        w_tx_next = w_shift_sh[0];
                    end
                end else if (i_s_tick) begin
                    w_s_next = r_s + 1'b1;
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_s_next     = '0;
                    w_state_next = STOP;
                    w_tx_next    = 1'b1;
                end else if (i_s_tick) begin
                    w_s_next = r_s + 1'b1;
                end
            end
            STOP: begin
                if (w_stop_end) begin
                    w_s_next     = '0;
                    w_state_next = IDLE;
                    w_tx_next    = 1'b1;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                end else if (i_s_tick) begin
                    w_s_next = r_s + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign o_tx           = r_tx;
    assign o_busy         = r_busy;
    assign o_tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed table-driven bench for uart_tx_cfg
module tb_uart_tx_cfg;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_s_tick;
    logic       i_tx_start;
    logic [7:0] i_din;
    logic [1:0] i_par_mode;
    logic       i_two_stop;
    logic       o_busy;
    logic       o_tx_done_tick;
    logic       o_tx;

    int total = 0;
    int bad   = 0;

    uart_tx_cfg #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_s_tick       (i_s_tick),
        .i_tx_start     (i_tx_start),
        .i_din          (i_din),
        .i_par_mode     (i_par_mode),
        .i_two_stop     (i_two_stop),
        .o_busy         (o_busy),
        .o_tx_done_tick (o_tx_done_tick),
        .o_tx           (o_tx)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] din;
        logic [1:0] mode;
        logic       two;
        int         div;
        logic       poke;
        logic       par_on;
        logic       exp_par;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int c);
        int idx;
        idx = (c - 1) / (16 * v.div);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return v.din[idx-1];
        if (idx == 9 && v.par_on) return v.exp_par;
        return 1'b1;
    endfunction

    task automatic run_frame(input int id, input vec_t v);
        int busy_len = 0;
        int done_cnt = 0;
        int done_at  = 0;
        int werr     = 0;
        int first_bad = 0;
        int par_seen = 0;
        int par_mid;
        logic e;
        par_mid = 9 * 16 * v.div + 8 * v.div;
        i_din      = v.din;
        i_par_mode = v.mode;
        i_two_stop = v.two;
        i_s_tick   = 1'b0;
        i_tx_start = 1'b1;
        @(posedge i_clk); #1;
        i_tx_start = 1'b0;
        check($sformatf("v%0d accept busy", id), int'(o_busy), 1);
        check($sformatf("v%0d accept tx", id), int'(o_tx), 0);
        for (int c = 1; c <= 3000; c++) begin
            i_s_tick = ((c % v.div) == 0);
            if (v.poke && ((c % 97) == 5)) begin
                i_tx_start = 1'b1;
                i_din      = ~v.din;
                i_par_mode = 2'b01;
                i_two_stop = 1'b1;
            end else begin
                i_tx_start = 1'b0;
            end
            if (o_busy) busy_len++;
            e = exp_bit(v, c);
            if (o_tx !== e) begin
                if (werr == 0) first_bad = c;
                werr++;
            end
            if (c == par_mid) par_seen = int'(o_tx);
            if (o_tx_done_tick) begin
                done_cnt++;
                done_at = c;
                check($sformatf("v%0d done-cycle busy", id), int'(o_busy), 0);
                check($sformatf("v%0d done-cycle tx", id), int'(o_tx), 1);
            end
            @(posedge i_clk); #1;
            if (done_at != 0) break;
        end
        i_tx_start = 1'b0;
        i_s_tick   = 1'b0;
        check($sformatf("v%0d waveform errors (first at cycle %0d)", id, first_bad), werr, 0);
        check($sformatf("v%0d busy length", id), busy_len, v.exp_cycles);
        check($sformatf("v%0d done pulses", id), done_cnt, 1);
        check($sformatf("v%0d done cycle", id), done_at, v.exp_cycles + 1);
        if (v.par_on) check($sformatf("v%0d parity bit", id), par_seen, int'(v.exp_par));
        check($sformatf("v%0d idle after frame", id), int'(o_busy), 0);
    endtask

    initial begin
        logic [7:0] w1;
        logic [7:0] w2;
        logic       tx_arr[1:400];
        int         done_n;
        int         idle_n;

        //          din    mode   two   div poke par_on exp_par cycles
        vecs[0] = '{8'h55, 2'b00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 160};
        vecs[1] = '{8'h55, 2'b01, 1'b0, 1, 1'b0, 1'b1, 1'b0, 176};
        vecs[2] = '{8'h55, 2'b10, 1'b0, 1, 1'b0, 1'b1, 1'b1, 176};
        vecs[3] = '{8'h07, 2'b01, 1'b0, 1, 1'b0, 1'b1, 1'b1, 176};
        vecs[4] = '{8'hA3, 2'b00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 176};
        vecs[5] = '{8'hA3, 2'b11, 1'b0, 1, 1'b0, 1'b0, 1'b0, 160};
        vecs[6] = '{8'h96, 2'b10, 1'b1, 1, 1'b0, 1'b1, 1'b1, 192};
        vecs[7] = '{8'h5A, 2'b00, 1'b0, 4, 1'b1, 1'b0, 1'b0, 640};

        i_reset = 1'b1; i_s_tick = 1'b0; i_tx_start = 1'b0;
        i_din = 8'h00; i_par_mode = 2'b00; i_two_stop = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset tx", int'(o_tx), 1);
        check("reset busy", int'(o_busy), 0);
        check("reset done", int'(o_tx_done_tick), 0);
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        for (int k = 0; k < 8; k++) begin
            run_frame(k, vecs[k]);
            repeat (2) @(posedge i_clk);
            #1;
        end

        // Back-to-back frames with start held high and data changing mid-frame.
        i_din = 8'h3C; i_par_mode = 2'b00; i_two_stop = 1'b0;
        i_s_tick = 1'b1; i_tx_start = 1'b1;
        @(posedge i_clk); #1;
        done_n = 0; idle_n = 0;
        for (int c = 1; c <= 323; c++) begin
            if (c == 50)  i_din = 8'hC3;
            if (c == 200) i_din = 8'h81;
            tx_arr[c] = o_tx;
            if (o_tx_done_tick) done_n++;
            if (!o_busy) idle_n++;
            @(posedge i_clk); #1;
        end
        i_tx_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w1[i] = tx_arr[16 * (i + 1) + 9];
            w2[i] = tx_arr[161 + 16 * (i + 1) + 9];
        end
        check("b2b frame1 word", int'(w1), 8'h3C);
        check("b2b frame2 word", int'(w2), 8'hC3);
        check("b2b frame2 start bit", int'(tx_arr[162]), 0);
        check("b2b frame3 start bit", int'(tx_arr[323]), 0);
        check("b2b done pulses", done_n, 2);
        check("b2b idle cycles", idle_n, 2);

        // Reset in the middle of frame 3's data bits.
        repeat (40) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        check("midreset tx", int'(o_tx), 1);
        check("midreset busy", int'(o_busy), 0);
        check("midreset done", int'(o_tx_done_tick), 0);
        done_n = 0; idle_n = 0;
        for (int c = 0; c < 200; c++) begin
            if (o_tx_done_tick) done_n++;
            if (!o_busy && o_tx) idle_n++;
            @(posedge i_clk); #1;
        end
        i_s_tick = 1'b0;
        check("post-reset done pulses", done_n, 0);
        check("post-reset idle cycles", idle_n, 200);
        run_frame(8, vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
